// File: rtl/operand_fetch_pkg.sv
// Shared defaults and the operand-bundle type for the operand-fetch stage.
// The optional OPERAND_FETCH_BYPASS_EN macro changes behaviour in the scoreboard and top.
package operand_fetch_pkg;

    localparam int DW_DEF  = 8;
    localparam int AW_DEF  = 2;
    localparam int OPW_DEF = 4;
    localparam int NREGS   = 2 ** AW_DEF;

    // One issued instruction as seen by execute.
    typedef struct packed {
        logic [DW_DEF-1:0]  a;
        logic [DW_DEF-1:0]  b;
        logic [AW_DEF-1:0]  rd;
        logic               wen;
        logic [OPW_DEF-1:0] op;
    } bundle_t;

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Pending-write scoreboard: tracks registers with an outstanding write and
// flags read-after-write / write-after-write hazards for the issuing instruction.
// With OPERAND_FETCH_BYPASS_EN defined, a same-cycle writeback resolves a hazard.
module operand_fetch_scoreboard
    import operand_fetch_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rt,
    input  logic [AW-1:0] rd,
    input  logic          wen,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_addr,
    output logic          hazard
);

    localparam int N = 2 ** AW;

    logic [N-1:0] pend;
    logic [N-1:0] pend_next;
    logic         rs_res;
    logic         rt_res;
    logic         rd_res;

    // Per-register next state: a new outstanding write beats a retiring one.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pend
            assign pend_next[gi] = (set_en && (set_addr == AW'(gi)))
                                 || (pend[gi] && !(wb_valid && (wb_addr == AW'(gi))));
        end
    endgenerate

`ifdef OPERAND_FETCH_BYPASS_EN
    // A writeback landing this cycle supplies the value, so it clears the hazard now.
    assign rs_res = wb_valid && (wb_addr == rs);
    assign rt_res = wb_valid && (wb_addr == rt);
    assign rd_res = wb_valid && (wb_addr == rd);
`else
    // Without forwarding the register file must be updated first.
    assign rs_res = 1'b0;
    assign rt_res = 1'b0;
    assign rd_res = 1'b0;
`endif

    assign hazard = (pend[rs] && !rs_res)
                 || (pend[rt] && !rt_res)
                 || (wen && pend[rd] && !rd_res);

    // Scoreboard register, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads the register file, stalls on scoreboard hazards and
// holds one operand bundle toward execute with a valid/ready handshake.
// Optional OPERAND_FETCH_BYPASS_EN forwards wb_data to operands in the writeback cycle.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int AW  = AW_DEF,
    parameter int OPW = OPW_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [AW-1:0]  in_rs,
    input  logic [AW-1:0]  in_rt,
    input  logic [AW-1:0]  in_rd,
    input  logic           in_wen,
    input  logic [OPW-1:0] in_op,
    output logic [AW-1:0]  raddr1,
    output logic [AW-1:0]  raddr2,
    input  logic [DW-1:0]  rdata1,
    input  logic [DW-1:0]  rdata2,
    input  logic           wb_valid,
    input  logic [AW-1:0]  wb_addr,
    input  logic [DW-1:0]  wb_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  out_a,
    output logic [DW-1:0]  out_b,
    output logic [AW-1:0]  out_rd,
    output logic           out_wen,
    output logic [OPW-1:0] out_op
);

    logic          hazard;
    logic          accept;
    logic [DW-1:0] sel_a;
    logic [DW-1:0] sel_b;

    assign raddr1   = in_rs;
    assign raddr2   = in_rt;
    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    operand_fetch_scoreboard #(
        .AW(AW)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .rs       (in_rs),
        .rt       (in_rt),
        .rd       (in_rd),
        .wen      (in_wen),
        .set_en   (accept && in_wen),
        .set_addr (in_rd),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .hazard   (hazard)
    );

`ifdef OPERAND_FETCH_BYPASS_EN
    // Writeback data is newer than the register-file read in the same cycle.
    assign sel_a = (wb_valid && (wb_addr == in_rs)) ? wb_data : rdata1;
    assign sel_b = (wb_valid && (wb_addr == in_rt)) ? wb_data : rdata2;
`else
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
    assign sel_a = rdata1;
    assign sel_b = rdata2;
`endif

    // Output bundle register: load on accept, drop on drain, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_rd    <= '0;
            out_wen   <= 1'b0;
            out_op    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_a     <= sel_a;
            out_b     <= sel_b;
            out_rd    <= in_rd;
            out_wen   <= in_wen;
            out_op    <= in_op;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
